// File: rtl/pixel_scanout_pkg.sv
// Shared types and constants for the pixel_scanout framebuffer scanout block.
package pixel_scanout_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_FRAME, FETCH, DRAIN, ABORT} state_t;
  typedef logic [23:0] pixel_t;
  localparam int BYTES_PER_PIXEL = 4;
endpackage

// File: rtl/pixel_scanout_if.sv
// Memory read port and display pixel stream of pixel_scanout; master = scanout side.
interface pixel_scanout_if #(parameter int ADDR_W = 32);
  import pixel_scanout_pkg::*;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [31:0]       mem_rdata_i;
  logic              pixel_valid_o;
  logic              pixel_ready_i;
  pixel_t            pixel_data_o;

  modport master (
    output mem_req_o, mem_addr_o, pixel_valid_o, pixel_data_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, pixel_ready_i
  );
  modport slave (
    input  mem_req_o, mem_addr_o, pixel_valid_o, pixel_data_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, pixel_ready_i
  );
endinterface

// File: rtl/pixel_scanout_fifo.sv
// pixel_fifo: synchronous FIFO, power-of-two depth, output read straight from storage (no bypass).
module pixel_fifo #(
  parameter  int DEPTH = 8,
  parameter  int DW    = 24,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == CW'(DEPTH));
  assign w_pop   = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = push_i && (!full_o || w_pop);

  always_ff @(posedge clk_i)
    if (w_push) r_mem[r_wptr] <= din_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign dout_o  = r_mem[r_rptr];
  assign count_o = r_count;
endmodule

// File: rtl/pixel_scanout.sv
// Framebuffer scanout: each frame_idx toggle fetches WIDTH*HEIGHT pixels and streams them out.
// Optional saturating underrun counter built only with PIXEL_SCANOUT_UNDERRUN_CNT_EN.
module pixel_scanout
  import pixel_scanout_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              enable_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              frame_idx_i,
  pixel_scanout_if.master   bus,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [15:0]       underrun_cnt_o
);
  localparam int N     = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(N + 1);
  localparam int OW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(N - 1);
  localparam logic [OW:0]      DEPTH_V = (OW + 1)'(FIFO_DEPTH);

  state_t            r_state, w_next;
  logic              r_fidx, r_fidx_prev;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_req_cnt, r_pix_cnt;
  logic [OW-1:0]     r_outst, w_fifo_cnt;
  logic [OW:0]       w_credit_used;
  logic              w_fifo_empty, w_fifo_full_unused, w_rdata_unused;
  pixel_t            w_fifo_dout;
  logic              w_active, w_toggle, w_gnt, w_dec, w_push, w_pop, w_valid, w_done;

  assign w_active      = (r_state == FETCH) || (r_state == DRAIN);
  assign w_toggle      = r_fidx ^ r_fidx_prev;
  assign w_credit_used = {1'b0, r_outst} + {1'b0, w_fifo_cnt};
  assign bus.mem_req_o = (r_state == FETCH) && (w_credit_used < DEPTH_V);
  assign bus.mem_addr_o = r_base + ADDR_W'(r_req_cnt) * ADDR_W'(BYTES_PER_PIXEL);
  assign w_gnt   = bus.mem_req_o && bus.mem_gnt_i;
  assign w_dec   = bus.mem_rvalid_i && (r_outst != '0);
  // Responses landing during abort are dropped; the FIFO is flushed anyway.
  assign w_push  = bus.mem_rvalid_i && w_active;
  assign w_valid = w_active && !w_fifo_empty;
  assign w_pop   = w_valid && bus.pixel_ready_i;
  assign w_done  = (r_state == DRAIN) && w_pop && (r_pix_cnt == LAST);
  assign w_rdata_unused = ^bus.mem_rdata_i[31:24];

  assign bus.pixel_valid_o = w_valid;
  assign bus.pixel_data_o  = w_valid ? w_fifo_dout : '0;
  assign busy_o            = w_active || (r_state == ABORT);
  assign frame_done_o      = w_done;

  pixel_fifo #(.DEPTH(FIFO_DEPTH), .DW(24)) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (r_state == ABORT),
    .push_i  (w_push),
    .din_i   (bus.mem_rdata_i[23:0]),
    .pop_i   (w_pop),
    .dout_o  (w_fifo_dout),
    .count_o (w_fifo_cnt),
    .empty_o (w_fifo_empty),
    .full_o  (w_fifo_full_unused)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (enable_i) w_next = WAIT_FRAME;
      WAIT_FRAME: if (!enable_i) w_next = IDLE;
                  else if (w_toggle) w_next = FETCH;
      FETCH:      if (!enable_i) w_next = ABORT;
                  else if (w_gnt && r_req_cnt == LAST) w_next = DRAIN;
      DRAIN:      if (w_done) w_next = WAIT_FRAME;
                  else if (!enable_i) w_next = ABORT;
      ABORT:      if (r_outst == '0) w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= IDLE;
      r_fidx      <= 1'b0;
      r_fidx_prev <= 1'b0;
      r_base      <= '0;
      r_req_cnt   <= '0;
      r_pix_cnt   <= '0;
      r_outst     <= '0;
    end else begin
      r_state     <= w_next;
      r_fidx      <= frame_idx_i;
      r_fidx_prev <= r_fidx;
      if (r_state == WAIT_FRAME && w_next == FETCH) begin
        r_base    <= base_addr_i;
        r_req_cnt <= '0;
        r_pix_cnt <= '0;
      end else begin
        if (w_gnt) r_req_cnt <= r_req_cnt + 1'b1;
        if (w_pop) r_pix_cnt <= r_pix_cnt + 1'b1;
      end
      case ({w_gnt, w_dec})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PIXEL_SCANOUT_UNDERRUN_CNT_EN
  logic [15:0] r_underrun;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_underrun <= '0;
    else if (w_active && bus.pixel_ready_i && w_fifo_empty && r_underrun != 16'hFFFF)
      r_underrun <= r_underrun + 1'b1;
  end
  assign underrun_cnt_o = r_underrun;
`else
  assign underrun_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pixel_scanout.sv
// Scoreboard bench for pixel_scanout (4x2 frame, 4-deep FIFO) with a latency-programmable memory model.
module tb_pixel_scanout;
  import pixel_scanout_pkg::*;
  localparam int WIDTH = 4, HEIGHT = 2, DEPTH = 4, ADDR_W = 32, N = WIDTH * HEIGHT;

  logic              clk = 1'b0, rstn = 1'b0, enable = 1'b0, frame_idx = 1'b0;
  logic [ADDR_W-1:0] base = '0;
  logic              busy, frame_done;
  logic [15:0]       underrun;

  pixel_scanout_if #(.ADDR_W(ADDR_W)) bus ();

  pixel_scanout #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .enable_i       (enable),
    .base_addr_i    (base),
    .frame_idx_i    (frame_idx),
    .bus            (bus),
    .busy_o         (busy),
    .frame_done_o   (frame_done),
    .underrun_cnt_o (underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  logic [31:0] exp_addr_q[$];
  pixel_t      exp_pix_q[$];

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Memory contents: pixel bits derived from the address, junk in the top byte.
  function automatic pixel_t pix_of(input logic [31:0] a);
    return {a[7:0] ^ 8'h3C, a[15:0]};
  endfunction

  task automatic queue_frame(input logic [31:0] b);
    for (int k = 0; k < N; k++) begin
      exp_addr_q.push_back(b + 32'(4 * k));
      exp_pix_q.push_back(pix_of(b + 32'(4 * k)));
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct { int due; logic [31:0] data; } rsp_t;
  rsp_t rq[$];
  int   lat = 1, gnt_hold = 0, n_given = 0, grant_limit = 1000000, cyc = 0;

  initial begin
    rsp_t r;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      bus.mem_rvalid_i = 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = r.data;
      end
      bus.mem_gnt_i = 1'b0;
      if (bus.mem_req_o) begin
        if (gnt_hold > 0) gnt_hold--;
        else if (n_given < grant_limit) begin
          bus.mem_gnt_i = 1'b1;
          n_given++;
          rq.push_back('{cyc + lat, {8'hEE, pix_of(bus.mem_addr_o)}});
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int     mon_out = 0, mon_occ = 0, n_grants = 0, n_pops = 0, n_done = 0, model_under = 0;
  bit     in_abort = 0;
  logic   p_req = 0, p_gnt = 0, p_en = 0, p_valid = 0, p_ready = 0;
  logic [31:0] p_addr = '0;
  pixel_t p_data = '0;

  always @(negedge clk) if (rstn) begin
    if (bus.mem_req_o) check("credit", longint'(mon_out + mon_occ < DEPTH), 1);
    if (p_req && !p_gnt && p_en) begin
      check("req_hold", bus.mem_req_o, 1);
      check("addr_hold", bus.mem_addr_o, p_addr);
    end
    if (p_valid && !p_ready && p_en) begin
      check("valid_hold", bus.pixel_valid_o, 1);
      check("data_hold", bus.pixel_data_o, p_data);
    end
    if (bus.mem_req_o && bus.mem_gnt_i) begin
      n_grants++;
      if (exp_addr_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_grant: addr 0x%0h, expected no request", bus.mem_addr_o);
      end else check("grant_addr", bus.mem_addr_o, exp_addr_q.pop_front());
    end
    if (bus.pixel_valid_o && bus.pixel_ready_i) begin
      n_pops++;
      if (exp_pix_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_pixel: data 0x%0h, expected no pixel", bus.pixel_data_o);
      end else check("pixel", bus.pixel_data_o, exp_pix_q.pop_front());
    end
    if (frame_done) begin
      n_done++;
      check("done_after_last_pixel", exp_pix_q.size(), 0);
    end
    if (busy && bus.pixel_ready_i && !bus.pixel_valid_o && !in_abort) model_under++;
    // bookkeeping for next cycle's credit check
    if (bus.mem_req_o && bus.mem_gnt_i) mon_out++;
    if (bus.mem_rvalid_i) mon_out--;
    if (bus.mem_rvalid_i && busy) mon_occ++;
    if (bus.pixel_valid_o && bus.pixel_ready_i) mon_occ--;
    if (!busy) mon_occ = 0;
    p_req = bus.mem_req_o; p_gnt = bus.mem_gnt_i; p_en = enable; p_addr = bus.mem_addr_o;
    p_valid = bus.pixel_valid_o; p_ready = bus.pixel_ready_i; p_data = bus.pixel_data_o;
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (n_done < target && t < 500) begin cycles(1); t++; end
    check("frame_done_count", n_done, target);
    cycles(6);
    check("back_to_wait_frame", busy, 0);
    check("single_done_pulse", n_done, target);
  endtask

  task automatic check_underrun(input string name);
`ifdef PIXEL_SCANOUT_UNDERRUN_CNT_EN
    check(name, underrun, model_under);
`else
    check(name, underrun, 0);
`endif
  endtask

  initial begin
    int g0, p0, t, d0;
    bus.pixel_ready_i = 1'b0;
    cycles(3);
    check("rst_req", bus.mem_req_o, 0);
    check("rst_addr", bus.mem_addr_o, 0);
    check("rst_valid", bus.pixel_valid_o, 0);
    check("rst_data", bus.pixel_data_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_underrun", underrun, 0);
    rstn = 1'b1;
    cycles(1);
    enable = 1'b1; bus.pixel_ready_i = 1'b1;
    cycles(4);
    check("enable_no_start", busy, 0);

    // 1: basic frame, 1-cycle memory
    base = 32'h1000; lat = 1; queue_frame(32'h1000);
    frame_idx = ~frame_idx;
    wait_done(1);
    check("t1_grants", n_grants, 8);
    check("t1_pixels", n_pops, 8);
    check_underrun("t1_underrun");

    // 2: 5-cycle memory, grant withheld for 3 request cycles
    base = 32'h2000; lat = 5; gnt_hold = 3; queue_frame(32'h2000);
    frame_idx = ~frame_idx;
    wait_done(2);
    check("t2_grants", n_grants, 16);
    check_underrun("t2_underrun");

    // 3: display back-pressure for 20 cycles after two pixels
    base = 32'h3000; lat = 1; queue_frame(32'h3000);
    g0 = n_grants; p0 = n_pops; t = 0;
    frame_idx = ~frame_idx;
    while (n_pops < p0 + 2 && t < 200) begin cycles(1); t++; end
    check("t3_two_pixels", n_pops - p0, 2);
    bus.pixel_ready_i = 1'b0;
    cycles(20);
    check("t3_stall_req", bus.mem_req_o, 0);
    check("t3_stall_grants", n_grants - g0, 6);
    check("t3_stall_valid", bus.pixel_valid_o, 1);
    bus.pixel_ready_i = 1'b1;
    wait_done(3);
    check("t3_pixels", n_pops - p0, 8);
    check_underrun("t3_underrun");

    // 4: abort with two responses pending
    in_abort = 1; bus.pixel_ready_i = 1'b0;
    base = 32'h4000; lat = 5;
    for (int k = 0; k < 3; k++) exp_addr_q.push_back(32'h4000 + 32'(4 * k));
    g0 = n_grants; p0 = n_pops; d0 = n_done; grant_limit = n_given + 3; t = 0;
    frame_idx = ~frame_idx;
    while (!(n_grants - g0 == 3 && mon_out == 2) && t < 200) begin cycles(1); t++; end
    check("t4_pending", mon_out, 2);
    enable = 1'b0;
    cycles(1);
    check("t4_req_drop", bus.mem_req_o, 0);
    check("t4_busy_abort", busy, 1);
    bus.pixel_ready_i = 1'b1;
    t = 0;
    while (busy && t < 100) begin cycles(1); t++; end
    check("t4_abort_exit", busy, 0);
    cycles(4);
    check("t4_valid_low", bus.pixel_valid_o, 0);
    check("t4_no_done", n_done, d0);
    check("t4_no_pixels", n_pops, p0);
    check("t4_grants", n_grants - g0, 3);
    grant_limit = 1000000; in_abort = 0;
    enable = 1'b1;
    cycles(4);

    // 5: two toggles during FETCH are ignored; next toggle starts next frame
    base = 32'h5000; lat = 1; queue_frame(32'h5000);
    g0 = n_grants; t = 0;
    frame_idx = ~frame_idx;
    while (!busy && t < 50) begin cycles(1); t++; end
    cycles(1); frame_idx = ~frame_idx;
    cycles(3); frame_idx = ~frame_idx;
    wait_done(4);
    cycles(10);
    check("t5_one_frame", n_grants - g0, 8);
    check("t5_idle", busy, 0);
    queue_frame(32'h5000);
    frame_idx = ~frame_idx;
    wait_done(5);
    check("t5_second_frame", n_grants - g0, 16);
    check_underrun("t5_underrun");

    check("addr_queue_empty", exp_addr_q.size(), 0);
    check("pixel_queue_empty", exp_pix_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 500us");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pixel_scanout.md
Name: pixel_scanout

Overview:
- Framebuffer scanout controller feeding the display pixel stream (pixel_valid/pixel_ready/pixel_data).
- On each new display frame, fetches WIDTH*HEIGHT pixels from memory via a request/grant/response read port, buffers them in a small FIFO, and streams them to the display interface.
- Sits in the SoC between the bus fabric and the display output pins.

Parameters:
- WIDTH, 64: pixels per line.
- HEIGHT, 32: lines per frame.
- FIFO_DEPTH, 8: pixel buffer entries; power of two, ≥2.
- ADDR_W, 32: memory address width.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- enable_i  in  1  scanout enable (level)
- base_addr_i  in  ADDR_W  framebuffer base, byte address, word aligned; sampled at frame start
- frame_idx_i  in  1  display frame parity; each toggle requests a new frame
- mem_req_o  out  1  read request valid
- mem_addr_o  out  ADDR_W  read byte address
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid (in order, ≥1 cycle after gnt)
- mem_rdata_i  in  32  read data; pixel = [23:0], [31:24] ignored
- pixel_valid_o  out  1  pixel stream valid
- pixel_ready_i  in  1  display accepts pixel
- pixel_data_o  out  24  RGB888 pixel
- busy_o  out  1  frame in progress (state ≠ IDLE/WAIT_FRAME)
- frame_done_o  out  1  one-cycle pulse when the last pixel of a frame is accepted
- underrun_cnt_o  out  16  underrun counter (see Optional Feature)

Behaviour:
- Reset values: all outputs 0, FSM=IDLE, FIFO empty, counters 0, frame_idx history = 0.
- frame_idx_i is registered once internally. A toggle is defined as registered value ≠ previous registered value.
- FSM states:
  - IDLE: if enable_i=1, go to WAIT_FRAME.
  - WAIT_FRAME:
    - enable_i=0 → IDLE.
    - frame_idx toggle → FETCH. Latch base_addr_i; req_cnt=0; pix_cnt=0.
    - The first toggle after enable starts the first frame; no immediate start.
  - FETCH:
    - Issue reads while credit is available and req_cnt < WIDTH*HEIGHT.
    - When req_cnt reaches WIDTH*HEIGHT → DRAIN.
  - DRAIN:
    - When pix_cnt reaches WIDTH*HEIGHT, pulse frame_done_o → WAIT_FRAME.
- Request handshake:
  - mem_req_o/mem_addr_o are held stable until mem_gnt_i.
  - Address = base + 4*req_cnt; req_cnt increments on gnt.
  - mem_req_o must never drop without gnt, except on abort.
- Credit rule: a request may be raised only if outstanding + fifo_count < FIFO_DEPTH. Outstanding increments on gnt and decrements on rvalid; same-cycle gnt+rvalid leaves it unchanged.
- FIFO:
  - rvalid pushes mem_rdata_i[23:0]; credit guarantees it is never full on push.
  - pixel_valid_o = FIFO non-empty, registered-output FIFO.
  - A pop occurs on valid&&ready and increments pix_cnt.
  - Simultaneous push and pop are allowed at any occupancy, including empty with a bypass-free registered output (first-word latency ≥1 cycle after rvalid).
  - pixel_data_o is stable while valid && !ready.
- End-to-end latency: gnt → earliest pixel_valid_o = memory latency + 1 cycle.
- frame_idx toggles during FETCH/DRAIN are ignored (no queueing). A late frame is dropped, not double-fetched.
- Abort when enable_i=0 during FETCH/DRAIN:
  - Deassert mem_req_o next cycle.
  - Stop popping (pixel_valid_o=0), wait for outstanding==0 while discarding responses, flush FIFO, → IDLE.
  - No frame_done_o pulse.
- busy_o=1 in FETCH, DRAIN and during abort.
- Counter width: clog2(WIDTH*HEIGHT+1). No wrap within a frame.

Optional Feature:
- Macro: PIXEL_SCANOUT_UNDERRUN_CNT_EN.
- With the macro:
  - underrun_cnt_o increments each cycle in FETCH/DRAIN where pixel_ready_i=1 and the FIFO is empty.
  - Saturates at 0xFFFF.
  - Cleared only by reset.
- Without the macro: underrun_cnt_o is tied to 0 and the counter logic is absent.

Decomposition:
- Package pixel_scanout_pkg:
  - state enum (IDLE, WAIT_FRAME, FETCH, DRAIN, ABORT);
  - pixel_t (logic [23:0]);
  - BYTES_PER_PIXEL=4.
- One sub-module, pixel_fifo: synchronous FIFO, parameterised depth/width, with push/pop/count/empty/full.

Test Plan:
- WIDTH=4, HEIGHT=2, base 0x1000, 1-cycle memory, ready always 1:
  - Toggle frame_idx → 8 grants at 0x1000..0x101C.
  - 8 pixels out in order equal to rdata[23:0].
  - One frame_done_o pulse, then WAIT_FRAME.
- Memory latency 5 cycles, FIFO_DEPTH=4:
  - outstanding+count never exceeds 4.
  - mem_req_o stays stable while gnt=0 for 3 cycles.
- pixel_ready_i=0 for 20 cycles mid-frame:
  - FIFO fills to 4, requests stall, pixel_data_o holds.
  - On release, remaining pixels stream and 8 total are delivered.
- enable_i dropped after 3 grants with 2 responses pending:
  - mem_req_o=0 next cycle; pending rvalids are discarded.
  - Then IDLE, pixel_valid_o=0, no frame_done_o.
- frame_idx toggled twice during FETCH:
  - Exactly one frame fetched; the next frame starts only on the next toggle in WAIT_FRAME.
- With PIXEL_SCANOUT_UNDERRUN_CNT_EN, 3-cycle memory latency, ready=1:
  - underrun_cnt_o equals the count of empty-FIFO ready cycles (≥4 at frame start).
  - Without the macro it reads 0.
